// File: rtl/keyseq_lock.sv
// Read-sequence key lock: matches windowed read address nibbles, then serves an LFSR keystream.
// Optional KEYSEQ_LOCK_DECOY_EN adds a decoy LFSR that drives sdrd_o while locked.
module keyseq_lock #(
    parameter int                   STATE_W    = 6,
    parameter int                   KEY_W      = 4,
    parameter int                   KEY_LEN    = 4,
    parameter logic [8*KEY_W-1:0]   KEY_SEQ    = {16'h0000, 16'h8B9A},
    parameter logic [1:0]           WIN_BASE   = 2'b01,
    parameter logic [STATE_W-1:0]   LFSR_TAPS  = 6'b110000,
    parameter logic [STATE_W-1:0]   SEED       = 6'b000001,
    parameter logic [KEY_W-1:0]     RELOCK_KEY = 4'h0,
    parameter int                   MAX_READS  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sser_n,
    input  logic               br_w,
    input  logic [1:0]         ba_win,
    input  logic [KEY_W-1:0]   ba_key,
    output logic               sdrd_o,
    output logic               sdrd_oe,
    output logic               unlocked_o,
    output logic [2:0]         step_o,
    output logic [STATE_W-1:0] state_o
);

    if (KEY_LEN > 8 || KEY_LEN < 1 || STATE_W < 3 || STATE_W > 16) begin : g_bad_param
        $error("keyseq_lock: illegal KEY_LEN or STATE_W");
    end

    localparam int                 CNT_W     = 16;
    localparam logic [2:0]         LAST_IDX  = 3'(KEY_LEN - 1);
    localparam logic [STATE_W-1:0] SEED_EFF  =
        (SEED == '0) ? STATE_W'(1) : SEED;

    typedef enum logic {
        LOCKED   = 1'b0,
        UNLOCKED = 1'b1
    } lock_state_e;

    lock_state_e        st_q, st_d;
    logic [2:0]         idx_q, idx_d;
    logic [STATE_W-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               qual_q;

    logic               qual;
    logic               evt;
    logic [KEY_W-1:0]   cur_key;
    logic [KEY_W-1:0]   first_key;
    logic [STATE_W-1:0] lfsr_nx;
    logic [CNT_W:0]     cnt_inc;
    logic               expire;

    assign qual      = ~sser_n & br_w & (ba_win == WIN_BASE);
    assign evt       = qual & ~qual_q;
    assign cur_key   = KEY_SEQ[KEY_W*idx_q +: KEY_W];
    assign first_key = KEY_SEQ[KEY_W-1:0];
    assign lfsr_nx   = {lfsr_q[STATE_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    assign cnt_inc   = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign expire    = (MAX_READS != 0) && (cnt_inc == (CNT_W+1)'(MAX_READS));

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= LOCKED;
            idx_q  <= '0;
            lfsr_q <= SEED_EFF;
            cnt_q  <= '0;
            qual_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
            qual_q <= qual;
        end
    end

    always_comb begin
        st_d   = st_q;
        idx_d  = idx_q;
        lfsr_d = lfsr_q;
        cnt_d  = cnt_q;
        if (evt) begin
            unique case (st_q)
                LOCKED: begin
                    if (ba_key == cur_key && idx_q == LAST_IDX) begin
                        st_d   = UNLOCKED;
                        lfsr_d = SEED_EFF;
                        cnt_d  = '0;
                        idx_d  = '0;
                    end else if (ba_key == cur_key) begin
                        idx_d = idx_q + 3'd1;
                    end else begin
                        // A mismatching key may itself be a valid first step.
                        idx_d = (ba_key == first_key) ? 3'd1 : 3'd0;
                    end
                end
                UNLOCKED: begin
                    if (ba_key == RELOCK_KEY) begin
                        st_d  = LOCKED;
                        idx_d = '0;
                    end else begin
                        lfsr_d = lfsr_nx;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_inc[CNT_W-1:0];
                        end
                        if (expire) begin
                            st_d  = LOCKED;
                            idx_d = '0;
                        end
                    end
                end
                default: st_d = LOCKED;
            endcase
        end
    end

    assign sdrd_oe    = qual;
    assign unlocked_o = (st_q == UNLOCKED);
    assign step_o     = idx_q;
    assign state_o    = lfsr_q;

`ifdef KEYSEQ_LOCK_DECOY_EN
    localparam logic [STATE_W-1:0] DECOY_SEED =
        (~SEED_EFF == '0) ? STATE_W'(1) : ~SEED_EFF;

    logic [STATE_W-1:0] decoy_q, decoy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            decoy_q <= DECOY_SEED;
        end else begin
            decoy_q <= decoy_d;
        end
    end

    always_comb begin
        decoy_d = decoy_q;
        if (evt && st_q == LOCKED) begin
            decoy_d = {decoy_q[STATE_W-2:0], ^(decoy_q & LFSR_TAPS)};
        end
    end

    assign sdrd_o = unlocked_o ? lfsr_q[STATE_W-1] : decoy_q[STATE_W-1];
`else
    assign sdrd_o = unlocked_o ? lfsr_q[STATE_W-1] : 1'b0;
`endif

endmodule

// File: tb/tb_keyseq_lock.sv
// Directed bench for keyseq_lock: unlock, keystream, relock, expiry and reset collision.
// A second instance with MAX_READS=3 shares the stimulus.
module tb_keyseq_lock;

    logic       clk = 1'b0;
    logic       rst;
    logic       sser_n;
    logic       br_w;
    logic [1:0] ba_win;
    logic [3:0] ba_key;

    logic       sdrd_o, sdrd_oe, unlocked_o;
    logic [2:0] step_o;
    logic [5:0] state_o;

    logic       m_sdrd_o, m_sdrd_oe, m_unlocked_o;
    logic [2:0] m_step_o;
    logic [5:0] m_state_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    keyseq_lock dut (
        .clk       (clk),
        .rst       (rst),
        .sser_n    (sser_n),
        .br_w      (br_w),
        .ba_win    (ba_win),
        .ba_key    (ba_key),
        .sdrd_o    (sdrd_o),
        .sdrd_oe   (sdrd_oe),
        .unlocked_o(unlocked_o),
        .step_o    (step_o),
        .state_o   (state_o)
    );

    keyseq_lock #(.MAX_READS(3)) dut_m (
        .clk       (clk),
        .rst       (rst),
        .sser_n    (sser_n),
        .br_w      (br_w),
        .ba_win    (ba_win),
        .ba_key    (ba_key),
        .sdrd_o    (m_sdrd_o),
        .sdrd_oe   (m_sdrd_oe),
        .unlocked_o(m_unlocked_o),
        .step_o    (m_step_o),
        .state_o   (m_state_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus access held for cyc clocks; sd/oe sampled before the first edge.
    task automatic acc(input logic [1:0] win, input logic rd,
                       input logic [3:0] key, input int cyc,
                       output logic sd, output logic oe);
        @(negedge clk);
        sser_n = 1'b0;
        br_w   = rd;
        ba_win = win;
        ba_key = key;
        #1;
        sd = sdrd_o;
        oe = sdrd_oe;
        repeat (cyc) @(negedge clk);
        sser_n = 1'b1;
        br_w   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] key, output logic sd);
        logic oe;
        acc(2'b01, 1'b1, key, 1, sd, oe);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic       sd, oe;
    logic [5:0] sdv;
    logic [5:0] exp_sdv;
    logic [3:0] keys [4];
    logic [2:0] steps [4];
    logic [5:0] ks [6];
    logic [3:0] seq6 [6];
    logic [2:0] st6 [6];

    initial begin
        keys  = '{4'hA, 4'h9, 4'hB, 4'h8};
        steps = '{3'd1, 3'd2, 3'd3, 3'd0};
        ks    = '{6'b000010, 6'b000100, 6'b001000,
                  6'b010000, 6'b100001, 6'b000011};
        seq6  = '{4'hA, 4'h9, 4'hA, 4'h9, 4'hB, 4'h8};
        st6   = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd0};
        rst = 1'b1; sser_n = 1'b1; br_w = 1'b0;
        ba_win = 2'b00; ba_key = 4'h0;
        do_reset();

        #1;
        chk("rst_unlocked", 32'(unlocked_o), 32'd0);
        chk("rst_step", 32'(step_o), 32'd0);
        chk("rst_state", 32'(state_o), 32'h01);
        chk("rst_oe", 32'(sdrd_oe), 32'd0);
        chk("rst_sd", 32'(sdrd_o), 32'd0);

        // Locked probe: key 5 never matches step 0.
        for (int i = 0; i < 6; i++) begin
            acc(2'b01, 1'b1, 4'h5, 1, sd, oe);
            sdv[i] = sd;
        end
`ifdef KEYSEQ_LOCK_DECOY_EN
        exp_sdv = 6'b011111;
`else
        exp_sdv = 6'b000000;
`endif
        chk("locked_sd", 32'(sdv), 32'(exp_sdv));
        chk("locked_oe", 32'(oe), 32'd1);
        chk("locked_step", 32'(step_o), 32'd0);

        for (int i = 0; i < 4; i++) begin
            rd(keys[i], sd);
            chk($sformatf("unl_step%0d", i), 32'(step_o), 32'(steps[i]));
            chk($sformatf("unl_flag%0d", i), 32'(unlocked_o),
                32'(i == 3));
        end
        chk("unl_seed", 32'(state_o), 32'h01);

        for (int i = 0; i < 6; i++) begin
            rd(4'h5, sd);
            sdv[i] = sd;
            chk($sformatf("ks_state%0d", i), 32'(state_o), 32'(ks[i]));
        end
        chk("ks_sd", 32'(sdv), 32'(6'b100000));

        rd(4'h0, sd);
        chk("relock_flag", 32'(unlocked_o), 32'd0);
        chk("relock_state", 32'(state_o), 32'h03);
        chk("relock_sd", 32'(sdrd_o), 32'd0);

        for (int i = 0; i < 6; i++) begin
            rd(seq6[i], sd);
            chk($sformatf("restart_step%0d", i), 32'(step_o), 32'(st6[i]));
        end
        chk("restart_unl", 32'(unlocked_o), 32'd1);
        chk("restart_seed", 32'(state_o), 32'h01);

        acc(2'b01, 1'b1, 4'h5, 10, sd, oe);
        chk("held_state", 32'(state_o), 32'h02);
        acc(2'b01, 1'b0, 4'h0, 1, sd, oe);
        chk("write_oe", 32'(oe), 32'd0);
        acc(2'b10, 1'b1, 4'h0, 1, sd, oe);
        chk("win_oe", 32'(oe), 32'd0);
        chk("nochange_state", 32'(state_o), 32'h02);
        chk("nochange_unl", 32'(unlocked_o), 32'd1);

        // Reset collides with the final key event.
        rd(4'h0, sd);
        chk("pre_coll_lock", 32'(unlocked_o), 32'd0);
        chk("pre_coll_state", 32'(state_o), 32'h02);
        for (int i = 0; i < 3; i++) rd(keys[i], sd);
        chk("pre_coll_step", 32'(step_o), 32'd3);
        @(negedge clk);
        rst = 1'b1; sser_n = 1'b0; br_w = 1'b1;
        ba_win = 2'b01; ba_key = 4'h8;
        @(negedge clk);
        rst = 1'b0; sser_n = 1'b1; br_w = 1'b0;
        #1;
        chk("coll_unl", 32'(unlocked_o), 32'd0);
        chk("coll_state", 32'(state_o), 32'h01);
        chk("coll_step", 32'(step_o), 32'd0);

        do_reset();
        for (int i = 0; i < 4; i++) rd(keys[i], sd);
        chk("max_unl", 32'(m_unlocked_o), 32'd1);
        rd(4'h5, sd);
        rd(4'h5, sd);
        chk("max_2nd", 32'(m_unlocked_o), 32'd1);
        rd(4'h5, sd);
        chk("max_3rd", 32'(m_unlocked_o), 32'd0);
        chk("max_state", 32'(m_state_o), 32'h08);
        chk("max_step", 32'(m_step_o), 32'd0);
        chk("max_free", 32'(unlocked_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/keyseq_lock.md
Name: keyseq_lock

Overview:
- Parametrised successor to the 16V8 read-sequence key decoder.
- Watches qualified bus reads in a window and matches a programmable sequence of address nibbles.
- Once unlocked, each qualified read returns one bit of a keystream from an LFSR of configurable width and taps.
- Sits on the slow peripheral bus beside the cartridge/option-ROM decode. Adds relock-by-key and read-count expiry, which the 16V8 decoder cannot do.

Parameters:
- STATE_W, 6: LFSR width (3..16).
- KEY_W, 4: width of the key address field.
- KEY_LEN, 4: number of steps in the unlock sequence (1..8).
- KEY_SEQ, 16'h8B9A: packed sequence. Step i is KEY_SEQ[KEY_W*i +: KEY_W]. Default order is A, 9, B, 8.
- WIN_BASE, 2'b01: required value of ba_win.
- LFSR_TAPS, 6'b110000: feedback tap mask.
- SEED, 6'b000001: LFSR value loaded on reset and on unlock. A value of 0 is replaced by 1.
- RELOCK_KEY, 4'h0: key value that relocks the block when read while unlocked.
- MAX_READS, 0: number of keystream reads before auto-relock. 0 means unlimited.

Ports:
- clk, in, 1: single clock. All state updates on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- sser_n, in, 1: peripheral select, active low.
- br_w, in, 1: bus direction. 1 means read.
- ba_win, in, 2: window address bits (BA13:12).
- ba_key, in, KEY_W: key address bits (BA7:4 by default).
- sdrd_o, out, 1: response data bit.
- sdrd_oe, out, 1: response output enable. Drives the tristate at top level.
- unlocked_o, out, 1: block is in the UNLOCKED state.
- step_o, out, 3: current match index.
- state_o, out, STATE_W: current LFSR value, for debug.

Behaviour:
- Qualification: qual = ~sser_n & br_w & (ba_win == WIN_BASE). This is combinational.
- Event: qual_d is qual registered on clk. event = qual & ~qual_d. Exactly one step per access, however long the access lasts.
- Reset: state=LOCKED, step_o=0, lfsr=SEED, qual_d=0, read count=0, unlocked_o=0. sdrd_oe follows qual, so it is 0 while idle. rst takes priority over any event in the same cycle.
- FSM state LOCKED (step_o = idx), on an event:
  - If ba_key == KEY_SEQ[idx] and idx == KEY_LEN-1: go to UNLOCKED, lfsr <= SEED, count <= 0, idx <= 0.
  - Else if ba_key == KEY_SEQ[idx]: idx <= idx+1.
  - Else (mismatch): idx <= (ba_key == KEY_SEQ[0]) ? 1 : 0. This allows an immediate restart.
- FSM state UNLOCKED, on an event:
  - If ba_key == RELOCK_KEY: go to LOCKED, idx <= 0, no LFSR step.
  - Else: lfsr <= {lfsr[STATE_W-2:0], ^(lfsr & LFSR_TAPS)} and count <= count+1.
  - If MAX_READS != 0 and count+1 == MAX_READS, also go to LOCKED after that step.
  - The count saturates and never wraps.
- Output timing: sdrd_o = unlocked_o ? lfsr[STATE_W-1] : 0. It is combinational from registered state. The bit presented during access N is the pre-advance value. The advance takes effect at the clk edge that sees the event.
- Mid-access changes: sdrd_oe = qual. An unlock or relock in the middle of an access changes sdrd_o one cycle after the event, while the same access is still asserted. This is intended.
- A KEY_SEQ step equal to RELOCK_KEY is legal. It matters only in the state where it is tested.
- Reads outside the window, and writes, have no effect.
- Elaboration errors: KEY_LEN > 8, or STATE_W < 3.

Optional Feature:
- Macro: KEYSEQ_LOCK_DECOY_EN.
- When defined: a second free-running STATE_W LFSR (same taps, seed ~SEED) steps on every event while LOCKED. sdrd_o outputs its MSB while LOCKED, so a probe of a locked part sees noise.
- When undefined: sdrd_o is 0 while LOCKED and the decoy logic is absent.

Test Plan:
- Reset, then reads with ba_key A, 9, B, 8, one access each → unlocked_o=1 after the 4th event; step_o reads 1, 2, 3, 0.
- Unlock, then 6 reads with ba_key=4'h5 → sdrd_o = 0, 0, 0, 0, 0, 1; state_o after the 6th read = 6'b000011 (successive values 000010, 000100, 001000, 010000, 100001, 000011).
- Sequence A, 9, A, 9, B, 8 → A restarts matching at idx=1, and unlock occurs on the final 8.
- Unlocked, read ba_key=0 → unlocked_o=0 next cycle, LFSR unchanged; a new A, 9, B, 8 sequence reloads SEED.
- MAX_READS=3: unlock, then 3 reads → relock after the 3rd. A held qual lasting 10 cycles counts as 1 event. A write (br_w=0) or a read with ba_win=2'b10 → no change.
- rst asserted on the same cycle as the final key event → LOCKED, lfsr=SEED. With KEYSEQ_LOCK_DECOY_EN defined, locked reads toggle sdrd_o per the decoy sequence seeded with 6'b111110.
